// File: rtl/unidade_busca_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package busca_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } estado_busca_t;

    localparam int BUSCA_ADDR_W     = 8;
    localparam int BUSCA_INSTR_W    = 32;
    localparam int CONFIRM_SYNC_LEN = 2;

    // Default-width queue entry; the top rebuilds it at its own parameter widths.
    typedef struct packed {
        logic [BUSCA_ADDR_W-1:0]  pc;
        logic [BUSCA_INSTR_W-1:0] instr;
    } entrada_busca_t;

endpackage

// File: rtl/unidade_busca_if.sv
// Fetch unit bus: instruction-memory port, decode handoff and control inputs.
interface unidade_busca_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_plus_one;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic [ADDR_W-1:0]  resume_pc;
    logic               confirm;
    logic               halted;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_one, halted,
        input  imem_rdata, out_ready, redirect, redirect_pc, halt, resume_pc, confirm
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus_one, halted,
        output imem_rdata, out_ready, redirect, redirect_pc, halt, resume_pc, confirm
    );
endinterface

// File: rtl/unidade_busca_fila.sv
// fila_busca: power-of-two prefetch FIFO with flush; pointers wrap naturally.
module fila_busca
    import busca_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = entrada_busca_t
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  T                      wdata_i,
    output T                      rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                  empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && (count_q != (PTR_W+1)'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: a slot is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: PC, imem request, epoch-tagged prefetch queue, HLT/confirm resume.
// BUSCA_PERF_EN adds saturating fetch/flush/stall counters.
module unidade_busca
    import busca_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    unidade_busca_if.master bus
`ifdef BUSCA_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [15:0]     perf_flushes,
    output logic [31:0]     perf_stall
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entrada_t;

    estado_busca_t               state_q, state_d;
    logic [ADDR_W-1:0]           fetch_pc_q, fetch_pc_d, req_pc_q;
    logic                        epoch_q, epoch_d, infl_q, req_epoch_q;
    logic [CONFIRM_SYNC_LEN-1:0] sync_q;
    logic                        conf_prev_q;
    logic                        req, flush, push, pop, empty, room, conf_edge;
    logic [CNT_W-1:0]            count;
    entrada_t                    push_data, head;

    assign conf_edge = sync_q[CONFIRM_SYNC_LEN-1] & ~conf_prev_q;
    // A slot is reserved for every outstanding request, so a response never overflows.
    assign room = ({1'b0, count} + {{CNT_W{1'b0}}, infl_q}) < (CNT_W+1)'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        req        = 1'b0;
        flush      = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.halt) begin
                    flush   = 1'b1;
                    epoch_d = ~epoch_q;
                    state_d = HALT;
                end else if (bus.redirect) begin
                    flush      = 1'b1;
                    epoch_d    = ~epoch_q;
                    fetch_pc_d = bus.redirect_pc;
                end else if (room) begin
                    req        = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                end
            end
            HALT: begin
                if (conf_edge) begin
                    state_d    = RUN;
                    fetch_pc_d = bus.resume_pc;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            epoch_q     <= 1'b0;
            infl_q      <= 1'b0;
            req_epoch_q <= 1'b0;
            req_pc_q    <= '0;
            sync_q      <= '0;
            conf_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            epoch_q     <= epoch_d;
            infl_q      <= req;
            req_epoch_q <= epoch_q;
            req_pc_q    <= fetch_pc_q;
            sync_q      <= {sync_q[CONFIRM_SYNC_LEN-2:0], bus.confirm};
            conf_prev_q <= sync_q[CONFIRM_SYNC_LEN-1];
        end
    end

    // Responses from a superseded epoch are discarded; flush also wins over a same-cycle push.
    assign push      = infl_q && (req_epoch_q == epoch_q) && !flush;
    assign pop       = !empty && bus.out_ready;
    assign push_data = {req_pc_q, bus.imem_rdata};

    fila_busca #(
        .DEPTH (DEPTH),
        .T     (entrada_t)
    ) u_fila (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (push_data),
        .rdata_o (head),
        .count_o (count),
        .empty_o (empty)
    );

    assign bus.imem_req        = req & ~reset;
    assign bus.imem_addr       = fetch_pc_q;
    assign bus.out_valid       = ~empty;
    assign bus.out_instr       = empty ? '0 : head.instr;
    assign bus.out_pc          = empty ? '0 : head.pc;
    assign bus.out_pc_plus_one = empty ? '0 : head.pc + ADDR_W'(1);
    assign bus.halted          = (state_q == HALT);

`ifdef BUSCA_PERF_EN
    logic [31:0] fetched_q, stall_q;
    logic [15:0] flushes_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            flushes_q <= '0;
            stall_q   <= '0;
        end else begin
            if (push && !(&fetched_q))  fetched_q <= fetched_q + 32'd1;
            if (flush && !(&flushes_q)) flushes_q <= flushes_q + 16'd1;
            if (state_q == RUN && empty && !(&stall_q)) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushes = flushes_q;
    assign perf_stall   = stall_q;
`endif
endmodule
